blink_mode_ctrl: RTL and testbench

//   Controller that sequences the board LED through selectable display modes.

---
 rtl/blink_pkg.sv | 16 +
 rtl/tick_gen.sv | 36 +++
 rtl/blink_mode_ctrl.sv | 91 +++++++++
 tb/tb_blink_mode_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared mode encoding for the LED mode controller.
package blink_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF        = 3'd0,
        MODE_ON         = 3'd1,
        MODE_BLINK_SLOW = 3'd2,
        MODE_BLINK_FAST = 3'd3,
        MODE_PATTERN    = 3'd4
    } mode_e;

    localparam logic [MODE_W-1:0] MODE_LAST = MODE_PATTERN;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle registered strobe every CLK_HZ/TICK_HZ cycles.
module tick_gen #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 10,
    parameter int unsigned CNT_W   = 32
) (
    input  logic clk_in,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("tick_gen: CLK_HZ/TICK_HZ must be at least 2");
        end
        if (((DIV - 1) >> CNT_W) != 0) begin : g_width_check
            $error("tick_gen: CNT_W too narrow to hold DIV-1");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == CNT_LAST);
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/blink_mode_ctrl.sv
// LED mode sequencer: OFF / ON / slow blink / fast blink / fixed pattern, stepped by mode_next.
module blink_mode_ctrl
    import blink_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TICK_HZ    = 10,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned SLOW_TICKS = 5,
    parameter logic [7:0]  PATTERN    = 8'b1010_0000
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              mode_next,
    output logic              led,
    output logic [MODE_W-1:0] mode,
    output logic              tick
);

    generate
        if (SLOW_TICKS < 1 || SLOW_TICKS > 15) begin : g_slow_check
            $error("blink_mode_ctrl: SLOW_TICKS must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] SLOW_LAST = 4'(SLOW_TICKS - 1);

    logic [MODE_W-1:0] mode_n;
    logic [3:0]        phase;
    logic [3:0]        phase_n;
    logic              led_n;
    logic [2:0]        pat_idx;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .CNT_W   (CNT_W)
    ) u_tick_gen (
        .clk_in (clk_in),
        .rst    (rst),
        .tick   (tick)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            mode  <= MODE_OFF;
            phase <= '0;
            led   <= 1'b0;
        end else begin
            mode  <= mode_n;
            phase <= phase_n;
            led   <= led_n;
        end
    end

    // A mode step takes priority over a coincident tick; unknown codes behave as OFF.
    always_comb begin
        mode_n  = mode;
        phase_n = phase;
        led_n   = led;
        pat_idx = '0;
        if (mode_next) begin
            mode_n  = (mode >= MODE_LAST) ? MODE_OFF : mode + 3'd1;
            phase_n = '0;
            case (mode_n)
                MODE_ON, MODE_BLINK_SLOW, MODE_BLINK_FAST: led_n = 1'b1;
                MODE_PATTERN:                              led_n = PATTERN[7];
                default:                                   led_n = 1'b0;
            endcase
        end else if (tick) begin
            case (mode)
                MODE_BLINK_FAST: led_n = ~led;
                MODE_BLINK_SLOW: begin
                    if (phase == SLOW_LAST) begin
                        led_n   = ~led;
                        phase_n = '0;
                    end else begin
                        phase_n = phase + 4'd1;
                    end
                end
                MODE_PATTERN: begin
                    // 7-(phase+1) in 3 bits is the bitwise inverse of phase+1
                    pat_idx = phase[2:0] + 3'd1;
                    phase_n = {1'b0, pat_idx};
                    led_n   = PATTERN[~pat_idx];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blink_mode_ctrl.sv
// Bench for blink_mode_ctrl: tick-count model checked every cycle plus literal spot checks.
module tb_blink_mode_ctrl;

    localparam int unsigned DIV  = 4;
    localparam int unsigned SLOW = 5;
    localparam logic [7:0]  PAT  = 8'b1010_0000;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       mode_next = 1'b0;
    logic       led;
    logic       tick;
    logic [2:0] mode;

    int checks = 0;
    int errors = 0;

    blink_mode_ctrl #(
        .CLK_HZ     (40),
        .TICK_HZ    (10),
        .CNT_W      (4),
        .SLOW_TICKS (SLOW),
        .PATTERN    (PAT)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .mode_next (mode_next),
        .led       (led),
        .mode      (mode),
        .tick      (tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycles since release give the tick; ticks counted since mode entry give the LED.
    int n_m = 0;
    int t_m = 0;
    int mode_m = 0;
    bit tick_m = 1'b0;
    bit tick_prev;

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            n_m = 0; t_m = 0; mode_m = 0; tick_m = 1'b0;
        end else begin
            tick_prev = tick_m;
            n_m++;
            tick_m = (n_m % DIV == 0);
            if (mode_next) begin
                mode_m = (mode_m == 4) ? 0 : mode_m + 1;
                t_m = 0;
            end else if (tick_prev) begin
                t_m++;
            end
        end
    end

    function automatic int led_model();
        case (mode_m)
            1:       return 1;
            2:       return ((t_m / SLOW) % 2 == 0) ? 1 : 0;
            3:       return (t_m % 2 == 0) ? 1 : 0;
            4:       return int'(PAT[7 - (t_m % 8)]);
            default: return 0;
        endcase
    endfunction

    always @(negedge clk_in) begin
        check("mode", mode, mode_m);
        check("led", led, led_model());
        check("tick", tick, tick_m);
    end

    task automatic pulse();
        mode_next = 1'b1;
        @(negedge clk_in);
        mode_next = 1'b0;
    endtask

    task automatic wait_tick();
        int cnt = 0;
        while (tick !== 1'b1 && cnt < 3 * DIV) begin
            @(negedge clk_in);
            cnt++;
        end
        if (tick !== 1'b1) check("tick_timeout", 0, 1);
    endtask

    int exp_pat[9] = '{0, 1, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_in);
            check($sformatf("tick_cycle%0d", k), tick, (k == 4 || k == 8 || k == 12));
        end

        // three pulses -> BLINK_FAST, first pulse coincides with a tick
        pulse();
        @(negedge clk_in);
        pulse();
        @(negedge clk_in);
        pulse();
        check("fast_mode", mode, 3);
        check("fast_entry_led", led, 1);
        repeat (3) @(negedge clk_in);
        check("fast_tick20", tick, 1);
        check("fast_led_before", led, 1);
        @(negedge clk_in);
        check("fast_led_after", led, 0);
        repeat (30) @(negedge clk_in);

        pulse();
        check("pat_mode", mode, 4);
        check("pat_entry_led", led, 1);
        for (int i = 0; i < 9; i++) begin
            wait_tick();
            @(negedge clk_in);
            check($sformatf("pat_step%0d", i + 1), led, exp_pat[i]);
        end

        // mode step on a tick cycle wins over the pattern advance
        wait_tick();
        pulse();
        check("coincide_mode", mode, 0);
        check("coincide_led", led, 0);

        mode_next = 1'b1;
        repeat (5) @(negedge clk_in);
        mode_next = 1'b0;
        check("held5_mode", mode, 0);

        pulse();
        pulse();
        check("slow_mode", mode, 2);
        check("slow_entry_led", led, 1);
        repeat (60) @(negedge clk_in);

        pulse();
        check("fast2_mode", mode, 3);
        repeat (6) @(negedge clk_in);
        @(posedge clk_in);
        #2 rst = 1'b1;
        #1;
        check("async_led", led, 0);
        check("async_tick", tick, 0);
        check("async_mode", mode, 0);
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_in);
            check($sformatf("rerelease_tick%0d", k), tick, (k == 4));
        end
        repeat (10) @(negedge clk_in);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
